// File: rtl/id_inst_pack.sv
// RV32 instruction encoder: packs an operation record into an instruction word
// and flags immediates that the selected format cannot represent. Two-stage
// valid/ready pipeline. Optional error counter: define INST_PACK_ERRCNT_EN.

`ifndef EXT_I
`define EXT_I 3'd1
`endif
`ifndef EXT_S
`define EXT_S 3'd2
`endif
`ifndef EXT_B
`define EXT_B 3'd3
`endif
`ifndef EXT_U
`define EXT_U 3'd4
`endif
`ifndef EXT_J
`define EXT_J 3'd5
`endif

module id_inst_pack (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 8;

  logic [INST_W-1:0] pack_inst;
  logic              pack_err;
  logic              s1_valid;
  logic [INST_W-1:0] s1_inst;
  logic              s1_err;
  logic              s2_ready;

  // Format-specific bit placement and representability check
  always_comb begin
    pack_inst = '0;
    pack_err  = 1'b0;
    case (op)
      `EXT_I: begin
        pack_inst = {imm[11:0], rs1, funct3, rd, opcode};
        pack_err  = !((imm[31:11] == '0) || (imm[31:11] == '1));
      end
      `EXT_S: begin
        pack_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        pack_err  = !((imm[31:11] == '0) || (imm[31:11] == '1));
      end
      `EXT_B: begin
        pack_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        pack_err  = !((imm[31:12] == '0) || (imm[31:12] == '1)) || imm[0];
      end
      `EXT_U: begin
        pack_inst = {imm[31:12], rd, opcode};
        pack_err  = (imm[11:0] != '0);
      end
      `EXT_J: begin
        pack_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        pack_err  = !((imm[31:20] == '0) || (imm[31:20] == '1)) || imm[0];
      end
      default: begin
        pack_inst = {funct7, rs2, rs1, funct3, rd, opcode};
        pack_err  = 1'b0;
      end
    endcase
  end

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  // Stage 1: capture packed word on accept
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      s1_valid <= 1'b0;
      s1_inst  <= '0;
      s1_err   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_inst <= pack_inst;
        s1_err  <= pack_err;
      end
    end
  end

  // Stage 2: output register, frozen while the consumer stalls
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      out_valid <= 1'b0;
      inst      <= '0;
      err       <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        inst <= s1_inst;
        err  <= s1_err;
      end
    end
  end

`ifdef INST_PACK_ERRCNT_EN
  // Saturating count of errored words handed to the consumer
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_id_inst_pack.sv
// Self-checking bench for id_inst_pack: directed vectors, randomized traffic
// against a queue-based reference model, back-pressure, reset and saturation.

`ifndef EXT_I
`define EXT_I 3'd1
`endif
`ifndef EXT_S
`define EXT_S 3'd2
`endif
`ifndef EXT_B
`define EXT_B 3'd3
`endif
`ifndef EXT_U
`define EXT_U 3'd4
`endif
`ifndef EXT_J
`define EXT_J 3'd5
`endif

module tb_id_inst_pack;

  logic        cpu_clk;
  logic        cpu_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        err;
  logic [7:0]  err_cnt;

  id_inst_pack dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst(inst), .err(err), .err_cnt(err_cnt)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [2:0]  op;
    logic [31:0] imm;
    int          age;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          ecnt_model = 0;
  logic [31:0] gold_inst;
  logic        gold_err;
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: representability from signed ranges, fields placed per format
  function automatic logic [32:0] ref_pack(input logic [2:0] f, input logic [6:0] oc,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
      input logic [4:0] a, input logic [4:0] b, input logic [31:0] v);
    longint s;
    logic   e;
    logic [31:0] w;
    s = longint'($signed(v));
    case (f)
      `EXT_I: begin e = !(s >= -2048 && s <= 2047); w = {v[11:0], a, f3, d, oc}; end
      `EXT_S: begin e = !(s >= -2048 && s <= 2047); w = {v[11:5], b, a, f3, v[4:0], oc}; end
      `EXT_B: begin
        e = !(s >= -4096 && s <= 4095 && (s % 2 == 0));
        w = {v[12], v[10:5], b, a, f3, v[4:1], v[11], oc};
      end
      `EXT_U: begin e = (v % 32'd4096) != 0; w = {v[31:12], d, oc}; end
      `EXT_J: begin
        e = !(s >= -1048576 && s <= 1048575 && (s % 2 == 0));
        w = {v[20], v[10:1], v[11], v[19:12], d, oc};
      end
      default: begin e = 1'b0; w = {f7, b, a, f3, d, oc}; end
    endcase
    return {e, w};
  endfunction

  // Decode-side immediate extractor, used for the round-trip property
  function automatic logic [31:0] decode_imm(input logic [2:0] f, input logic [31:0] i);
    case (f)
      `EXT_I: return {{20{i[31]}}, i[31:20]};
      `EXT_S: return {{20{i[31]}}, i[31:25], i[11:7]};
      `EXT_B: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      `EXT_U: return {i[31:12], 12'b0};
      `EXT_J: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_rec(input logic [2:0] f, input logic [6:0] oc, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
      input logic [31:0] v, input bit use_gold, input logic [31:0] g_inst, input logic g_err);
    logic [32:0] r;
    op = f; opcode = oc; funct3 = f3; funct7 = f7; rd = d; rs1 = a; rs2 = b; imm = v;
    r = ref_pack(f, oc, f3, f7, d, a, b, v);
    gold_inst = use_gold ? g_inst : r[31:0];
    gold_err  = use_gold ? g_err  : r[32];
  endtask

  task automatic rand_rec();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: v = $urandom & 32'hFFFFF000;
      default: v = 32'($urandom_range(0, 2097151)) - 32'd1048576;
    endcase
    set_rec(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom), v, 1'b0, 32'h0, 1'b0);
  endtask

  // One clock: inputs already driven after the falling edge
  task automatic tick();
    bit   acc, pop, exp_ov;
    exp_t e;
    #1;
    exp_ov = (q.size() > 0) && (q[0].age >= 1);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
    chk("err_cnt", 32'(err_cnt), 32'(ecnt_model));
    if (exp_ov && out_valid) begin
      chk("inst", inst, q[0].inst);
      chk("err", 32'(err), 32'(q[0].err));
      if (!q[0].err && q[0].op >= `EXT_I && q[0].op <= `EXT_J)
        chk("roundtrip", decode_imm(q[0].op, inst), q[0].imm);
    end
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    @(posedge cpu_clk);
    if (pop && q.size() > 0) begin
`ifdef INST_PACK_ERRCNT_EN
      if (q[0].err && ecnt_model < 255) ecnt_model++;
`endif
      void'(q.pop_front());
    end
    foreach (q[k]) q[k].age++;
    if (acc) begin
      e.inst = gold_inst; e.err = gold_err; e.op = op; e.imm = imm; e.age = 0;
      q.push_back(e);
    end
    last_acc = acc;
    @(negedge cpu_clk);
  endtask

  task automatic one_shot();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) tick();
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    cpu_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_rec(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0);
    @(negedge cpu_clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_inst", inst, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;

    // Directed vectors with literal expectations
    set_rec(`EXT_I, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093, 1'b0);
    one_shot();
    set_rec(`EXT_S, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423, 1'b0);
    one_shot();
    set_rec(`EXT_B, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3, 1'b0);
    one_shot();
    set_rec(`EXT_J, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b1, 32'h001000EF, 1'b0);
    one_shot();
    set_rec(`EXT_U, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7, 1'b0);
    one_shot();
    set_rec(`EXT_I, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b1, 32'h80000093, 1'b1);
    one_shot();
    set_rec(`EXT_B, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd6, 1'b0, 32'h0, 1'b0);
    one_shot();
    set_rec(`EXT_B, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0, 1'b0);
    gold_err = 1'b1;
    one_shot();

    // Back-pressure: only two records fit while the consumer stalls
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n = 0;
    rand_rec();
    for (int c = 0; c < 6; c++) begin
      tick();
      if (last_acc) begin n++; rand_rec(); end
    end
    chk("bp_accepts", 32'(n), 32'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && n < 4; c++) begin
      tick();
      if (last_acc) begin n++; rand_rec(); end
    end
    chk("bp_total", 32'(n), 32'd4);
    drain();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      rand_rec();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Asynchronous reset with both stages occupied
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 10 && q.size() < 2; c++) begin
      rand_rec();
      tick();
    end
    chk("full_before_rst", 32'(q.size()), 32'd2);
    in_valid = 1'b0;
    #2;
    cpu_rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_inst", inst, 32'h0);
    q.delete();
    ecnt_model = 0;
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    out_ready = 1'b1;
    rand_rec();
    one_shot();

    // Error counter saturation
    set_rec(`EXT_I, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b1, 32'h80000093, 1'b1);
    in_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 1000 && n < 300; c++) begin
      tick();
      if (last_acc) n++;
    end
    chk("sat_accepts", 32'(n), 32'd300);
    drain();
    #1;
`ifdef INST_PACK_ERRCNT_EN
    chk("err_cnt_sat", 32'(err_cnt), 32'hFF);
`else
    chk("err_cnt_off", 32'(err_cnt), 32'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_inst_pack.md
# id_inst_pack

- Instruction encoder: the write-side counterpart of the decode-stage immediate extractor.
- Accepts an operation record (format select, opcode, funct fields, register indices, 32-bit immediate) and packs it into a 32-bit RV32 instruction word.
- Checks that the immediate is representable in the selected format.
- Two-stage valid/ready pipeline; feeds the debug instruction-injection path and the instruction-memory loader.

## Interface
- No parameters.
- cpu_clk    in   1   clock; all state updates on rising edge
- cpu_rst_n  in   1   reset, asynchronous, active-low
- in_valid   in   1   input record valid
- in_ready   out  1   encoder can accept a record this cycle
- op         in   3   format select: `EXT_I`, `EXT_S`, `EXT_B`, `EXT_U`, `EXT_J` from defines.vh; any other value selects R-type
- opcode     in   7   instruction [6:0]
- funct3     in   3   placed at [14:12] in I/S/B/R formats
- funct7     in   7   placed at [31:25] in R format only
- rd, rs1, rs2  in  5 each   register indices
- imm        in   32  immediate, already sign-extended / byte offset
- out_valid  out  1   packed word valid
- out_ready  in   1   consumer accepts the word
- inst       out  32  packed instruction
- err        out  1   immediate not representable; qualified by out_valid
- err_cnt    out  8   saturating count of errored words delivered

## Operation
Packing, where imm[a:b] is taken from the input:
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- U: {imm[31:12], rd, opcode}
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- R (default): {funct7, rs2, rs1, funct3, rd, opcode}

Legality (err=1 when violated):
- I/S: imm[31:11] all equal.
- B: imm[31:12] all equal and imm[0]==0.
- U: imm[11:0]==0.
- J: imm[31:20] all equal and imm[0]==0.
- R: never errors.

Error handling and round-trip property:
- An errored record is still packed from the truncated bits and delivered with err=1; it is never dropped.
- Any legal record round-trips: the decode-side extractor applied to inst yields imm exactly.

## Timing
Pipeline structure:
- Stage 1 registers the packed word and err flag.
- Stage 2 is the output register driving inst/err/out_valid.
- Latency: accept at edge N produces out_valid=1 after edge N+1, i.e. 2 cycles.
- Throughput: 1 word/cycle while out_ready=1.

Handshake:
- s2_ready = !out_valid || out_ready.
- in_ready = !s1_valid || s2_ready; combinational and registered-state-only (no dependence on in_valid).
- A transfer occurs on valid && ready at a rising edge.
- While out_valid=1 && out_ready=0: inst and err stay stable, stage 1 holds, and in_ready falls once stage 1 is full. Exactly 2 records are absorbed during the stall.
- Simultaneous output pop and input push in the full state: both occur; no bubble, no loss.

Reset:
- out_valid=0, s1_valid=0, inst=32'h0, err=0, err_cnt=0.
- in_ready=1 during and after reset.
- Assertion mid-operation discards in-flight records immediately (asynchronous); no partial word is ever presented.

err_cnt:
- Increments on each delivered word (out_valid && out_ready) with err=1.
- Holds at 8'hFF.

## Configuration
- `INST_PACK_ERRCNT_EN` defined: err_cnt counter logic is compiled in as described above.
- Not defined: err_cnt is tied to 8'h00 and no counter flops exist; all other behaviour is identical.

## Test plan
- I, opcode 0010011, funct3 0, rd 1, rs1 0, imm 32'hFFFFFFFF -> inst 32'hFFF00093, err 0, out_valid exactly 2 cycles after accept.
- S (opcode 0100011, f3 010, rs1 1, rs2 2, imm 8) -> 32'h0020A423; B (opcode 1100011, f3 0, rs1/rs2 0, imm -4) -> 32'hFE000EE3; J (opcode 1101111, rd 1, imm 32'h800) -> 32'h001000EF; U (opcode 0110111, rd 5, imm 32'h12345000) -> 32'h123452B7; all err 0.
- I with imm 32'h00000800, rd 1, rs1 0, opcode 0010011 -> inst 32'h80000093, err 1, err_cnt increments to 1 with macro defined and stays 0 without it.
- B with imm 6 (odd bit clear) passes; B with imm 5 -> err 1.
- Back-pressure: stream 4 records with out_ready=0 -> in_ready drops after 2 accepts; releasing out_ready delivers all 4 in order with no duplicates.
- Assert cpu_rst_n low with both stages full -> out_valid 0 in the same cycle; after release the first new record emerges 2 cycles after accept.
- Error counter: 300 errored records delivered -> err_cnt saturates at 8'hFF.
